// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// FSM state encoding, the fetch abort value and small sizing helpers.
package imem_dmem_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_F = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  // Instruction handed to fetch when its transaction is aborted (addi x0,x0,0)
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Load data handed to the memory stage when its transaction is aborted
  localparam logic [31:0] DATA_ABORT_RDATA = 32'h0000_0000;

  // Byte address to word address; the two low bits are not used by the RAM
  function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

  // Number of bits needed to hold the value max_val (at least one)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 32'd1;
    while ((64'd1 << w) <= {32'd0, max_val}) begin
      w = w + 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the fetch/memory pipeline stages, the arbiter and the
// single-port memory wrapper. The slave view is the arbiter itself; the
// master view is whatever drives requests and models the memory.
interface imem_dmem_arbiter_if;

  // fetch stage side
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;

  // memory stage side
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_valid;

  // memory wrapper side
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_valid,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_rdata, dm_valid,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_valid,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_rdata, dm_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/imem_dmem_arbiter_timeout_counter.sv
// Generic bus-master watchdog: counts enabled cycles since the last clear and
// flags expiry once LIMIT cycles have elapsed. LIMIT = 0 never expires.
module arb_timeout_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned     LAST_I  = (LIMIT > 32'd0) ? (LIMIT - 32'd1) : 32'd0;
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(LAST_I);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_TOP = '1;

  logic [WIDTH-1:0] count_r;

  // Count enabled cycles since the last clear, holding at the top value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && (count_r != CNT_TOP)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  // The current cycle is the LIMIT-th enabled cycle since the clear
  assign expired = (LIMIT != 32'd0) && (count_r == LAST);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-port unified RAM between instruction fetch and
// loads/stores. One transaction in flight at a time; data wins ties unless it
// has starved a pending fetch for DATA_STREAK_MAX grants in a row. A watchdog
// aborts transactions the memory never acknowledges so the pipeline cannot hang.
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_STREAK_MAX = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imem_dmem_arbiter_if.slave   bus,
  output logic                 stall_f,
  output logic                 stall_m,
  output logic                 bus_err
);

  localparam int unsigned         STREAK_W     = cnt_width(DATA_STREAK_MAX);
  localparam int unsigned         TO_W         = cnt_width(TIMEOUT_CYCLES);
  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(DATA_STREAK_MAX);
  localparam logic [STREAK_W-1:0] STREAK_ONE   = STREAK_W'(1);

  arb_state_e          state_r;
  logic [STREAK_W-1:0] streak_r;
  logic                mem_req_r;
  logic                mem_we_r;
  logic [29:0]         mem_addr_r;
  logic [31:0]         mem_wdata_r;
  logic [3:0]          mem_be_r;
  logic [31:0]         if_rdata_r;
  logic                if_valid_r;
  logic [31:0]         dm_rdata_r;
  logic                dm_valid_r;
  logic                bus_err_r;

  logic                grant_d_s;
  logic                grant_f_s;
  logic                busy_s;
  logic                to_clr_s;
  logic                to_en_s;
  logic                to_expired_s;

  // Pick the winner of an idle cycle; data first unless it has starved fetch
  always_comb begin
    grant_d_s = 1'b0;
    grant_f_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (bus.dm_req && (!bus.if_req || (streak_r < STREAK_LIMIT))) begin
        grant_d_s = 1'b1;
      end else if (bus.if_req) begin
        grant_f_s = 1'b1;
      end else begin
        grant_d_s = 1'b0;
        grant_f_s = 1'b0;
      end
    end else begin
      grant_d_s = 1'b0;
      grant_f_s = 1'b0;
    end
  end

  assign busy_s   = (state_r == ST_BUSY_F) || (state_r == ST_BUSY_D);
  assign to_clr_s = grant_d_s || grant_f_s;
  assign to_en_s  = busy_s && !bus.mem_ack;

  arb_timeout_counter #(
    .WIDTH (TO_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (to_clr_s),
    .en      (to_en_s),
    .expired (to_expired_s)
  );

  // Arbiter FSM: capture operands on grant, hold the memory request until
  // ack or timeout, then return data with a one-cycle valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      streak_r    <= '0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_be_r    <= '0;
      if_rdata_r  <= '0;
      if_valid_r  <= 1'b0;
      dm_rdata_r  <= '0;
      dm_valid_r  <= 1'b0;
      bus_err_r   <= 1'b0;
    end else begin
      if_valid_r <= 1'b0;
      dm_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_d_s) begin
            state_r     <= ST_BUSY_D;
            mem_req_r   <= 1'b1;
            mem_we_r    <= bus.dm_we;
            mem_addr_r  <= word_addr(bus.dm_addr);
            mem_wdata_r <= bus.dm_wdata;
            mem_be_r    <= bus.dm_be;
            // only grants that bypass a waiting fetch count toward the streak
            if (bus.if_req) begin
              if (streak_r < STREAK_LIMIT) begin
                streak_r <= streak_r + STREAK_ONE;
              end else begin
                streak_r <= streak_r;
              end
            end else begin
              streak_r <= '0;
            end
          end else if (grant_f_s) begin
            state_r     <= ST_BUSY_F;
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= word_addr(bus.if_addr);
            mem_wdata_r <= 32'h0000_0000;
            mem_be_r    <= 4'hF;
            streak_r    <= '0;
          end else begin
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
          end
        end
        ST_BUSY_F, ST_BUSY_D: begin
          if (bus.mem_ack) begin
            // ack beats a simultaneous timeout
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
            if (state_r == ST_BUSY_F) begin
              if_rdata_r <= bus.mem_rdata;
              if_valid_r <= 1'b1;
            end else begin
              dm_rdata_r <= bus.mem_rdata;
              dm_valid_r <= 1'b1;
            end
          end else if (to_expired_s) begin
            // abort and release the requester with a harmless value
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
            bus_err_r <= 1'b1;
            if (state_r == ST_BUSY_F) begin
              if_rdata_r <= NOP_INSTR;
              if_valid_r <= 1'b1;
            end else begin
              dm_rdata_r <= DATA_ABORT_RDATA;
              dm_valid_r <= 1'b1;
            end
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_be    = mem_be_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.if_valid  = if_valid_r;
  assign bus.dm_rdata  = dm_rdata_r;
  assign bus.dm_valid  = dm_valid_r;
  assign bus_err       = bus_err_r;

  // a requester stalls while it asks and has not yet been answered
  assign stall_f = rst_n & bus.if_req & ~if_valid_r;
  assign stall_m = rst_n & bus.dm_req & ~dm_valid_r;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter with a scoreboard of expected memory
// transactions and a small memory model answering after a programmable delay.
module tb_imem_dmem_arbiter;
  import imem_dmem_arbiter_pkg::*;

  localparam int unsigned STREAK = 4;
  localparam int unsigned TMO    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stall_f, stall_m, bus_err;

  imem_dmem_arbiter_if bus ();

  imem_dmem_arbiter #(
    .DATA_STREAK_MAX (STREAK),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .stall_f (stall_f),
    .stall_m (stall_m),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    logic [29:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          tmo;
    bit          chk_gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_vec = 0;
  int   n_err = 0;
  bit   in_flight = 1'b0;
  int   req_cycles = 0;
  int   cyc = 0;
  int   last_valid_cyc = -100;
  bit   ack_en = 1'b1;
  int   ack_delay = 0;
  bit   hold_f = 1'b0;
  bit   hold_d = 1'b0;
  bit   exp_err = 1'b0;
  int   n_done = 0;

  function automatic logic [31:0] mem_model(input logic [29:0] a);
    return {a, 2'b10} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_d, input logic [31:0] byte_addr, input bit we,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input bit tmo, input bit gap);
    exp_t e;
    e.is_d    = is_d;
    e.addr    = byte_addr[31:2];
    e.we      = we;
    e.wdata   = wdata;
    e.be      = be;
    e.tmo     = tmo;
    e.chk_gap = gap;
    exp_q.push_back(e);
  endtask

  // one clock: observe the DUT just after the edge, then answer as the memory
  task automatic tick();
    logic [31:0] exp_rd;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.mem_req === 1'b1) begin
      if (!in_flight) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_mem_req", bus.mem_req, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          in_flight = 1'b1;
          req_cycles = 1;
          chk("issue_addr", bus.mem_addr, cur.addr);
          chk("issue_we", bus.mem_we, cur.we);
          chk("issue_be", bus.mem_be, cur.be);
          if (cur.is_d) chk("issue_wdata", bus.mem_wdata, cur.wdata);
          if (cur.chk_gap) chk("issue_gap", cyc - last_valid_cyc, 32'd1);
        end
      end else begin
        req_cycles++;
        chk("hold_addr", bus.mem_addr, cur.addr);
        chk("hold_we", bus.mem_we, cur.we);
        chk("hold_be", bus.mem_be, cur.be);
        if (cur.is_d) chk("hold_wdata", bus.mem_wdata, cur.wdata);
      end
    end
    if (bus.if_valid === 1'b1 || bus.dm_valid === 1'b1) begin
      if (!in_flight) begin
        chk("spurious_valid", {bus.if_valid, bus.dm_valid}, 32'd0);
      end else begin
        if (cur.tmo) exp_rd = cur.is_d ? 32'h0000_0000 : 32'h0000_0013;
        else         exp_rd = mem_model(cur.addr);
        chk("valid_port", {bus.if_valid, bus.dm_valid}, cur.is_d ? 32'd1 : 32'd2);
        chk("mem_req_at_valid", bus.mem_req, 32'd0);
        chk("rdata", cur.is_d ? bus.dm_rdata : bus.if_rdata, exp_rd);
        chk("req_len", req_cycles, cur.tmo ? TMO : ack_delay + 1);
        chk("stall_at_valid", cur.is_d ? stall_m : stall_f, 32'd0);
        if (cur.tmo) exp_err = 1'b1;
        chk("bus_err", bus_err, exp_err);
        in_flight = 1'b0;
        n_done++;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          bus.if_req = 1'b0;
          bus.dm_req = 1'b0;
        end else if (!cur.is_d && !hold_f) begin
          bus.if_req = 1'b0;
        end else if (cur.is_d && !hold_d) begin
          bus.dm_req = 1'b0;
        end
      end
    end
    bus.mem_ack   = (bus.mem_req === 1'b1) && ack_en && (req_cycles > ack_delay);
    bus.mem_rdata = bus.mem_ack ? mem_model(bus.mem_addr) : 32'hDEAD_BEEF;
  endtask

  // run until every queued transaction has completed, then idle briefly
  task automatic run(input int budget);
    int b;
    b = budget;
    while ((exp_q.size() != 0 || in_flight) && b > 0) begin
      tick();
      b--;
    end
    chk("run_budget", (exp_q.size() != 0) || in_flight, 32'd0);
    tick();
    tick();
  endtask

  initial begin
    int done0;
    int lat;
    int b;
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'h0;
    bus.dm_wdata = 32'h0; bus.dm_be = 4'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;

    // reset values, with a fetch request present to show stall is gated
    #12;
    chk("rst_mem_req", bus.mem_req, 32'd0);
    chk("rst_mem_we", bus.mem_we, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_be", bus.mem_be, 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_if_valid", bus.if_valid, 32'd0);
    chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
    chk("rst_dm_valid", bus.dm_valid, 32'd0);
    chk("rst_stall_f", stall_f, 32'd0);
    chk("rst_stall_m", stall_m, 32'd0);
    chk("rst_bus_err", bus_err, 32'd0);
    bus.if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // single fetch, zero-wait memory
    push(1'b0, 32'h0000_0010, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
    bus.if_addr = 32'h0000_0010;
    bus.if_req  = 1'b1;
    #1;
    chk("t1_stall_f_req", stall_f, 32'd1);
    done0 = n_done;
    lat = 0;
    while (lat < 6) begin
      tick();
      lat++;
      if (n_done != done0) break;
      chk("t1_stall_f_wait", stall_f, 32'd1);
    end
    chk("t1_latency", lat, 32'd2);
    run(20);

    // fetch and store arrive together: store first, fetch right after
    push(1'b1, 32'h0000_0200, 1'b1, 32'hCAFE_F00D, 4'b0011, 1'b0, 1'b0);
    push(1'b0, 32'h0000_0024, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1);
    bus.if_addr = 32'h0000_0024;
    bus.dm_addr = 32'h0000_0200; bus.dm_we = 1'b1;
    bus.dm_wdata = 32'hCAFE_F00D; bus.dm_be = 4'b0011;
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    run(40);

    // starvation limit: D,D,D,D,F,D,D,D,D,F; fetch address low bits ignored
    hold_f = 1'b1; hold_d = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) == 4) push(1'b0, 32'h0000_0103, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1);
      else push(1'b1, 32'h0000_0300, 1'b0, 32'h1111_2222, 4'hF, 1'b0, (i != 0));
    end
    bus.if_addr = 32'h0000_0103;
    bus.dm_addr = 32'h0000_0300; bus.dm_we = 1'b0;
    bus.dm_wdata = 32'h1111_2222; bus.dm_be = 4'hF;
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    run(100);
    hold_f = 1'b0; hold_d = 1'b0;

    // slow memory: outputs hold while operands change underneath
    ack_delay = 5;
    push(1'b1, 32'h0000_0400, 1'b0, 32'h1234_5678, 4'hC, 1'b0, 1'b0);
    bus.dm_addr = 32'h0000_0400; bus.dm_we = 1'b0;
    bus.dm_wdata = 32'h1234_5678; bus.dm_be = 4'hC;
    bus.dm_req = 1'b1;
    b = 10;
    while (!in_flight && b > 0) begin tick(); b--; end
    chk("t4_issued", in_flight, 32'd1);
    bus.dm_addr = 32'h0000_0800; bus.dm_wdata = 32'h0BAD_0BAD;
    bus.dm_be = 4'h1; bus.dm_we = 1'b1;
    b = 20;
    while (in_flight && b > 0) begin
      chk("t4_stall_m_wait", stall_m, 32'd1);
      tick();
      b--;
    end
    run(20);
    ack_delay = 0;

    // stray ack while idle produces nothing
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
    tick();
    chk("idle_ack_if_valid", bus.if_valid, 32'd0);
    chk("idle_ack_dm_valid", bus.dm_valid, 32'd0);
    chk("idle_ack_mem_req", bus.mem_req, 32'd0);
    tick();
    chk("idle_ack_if_valid2", bus.if_valid, 32'd0);
    chk("idle_ack_dm_valid2", bus.dm_valid, 32'd0);

    // unanswered fetch times out with a NOP and a sticky error
    ack_en = 1'b0;
    push(1'b0, 32'h0000_0040, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
    bus.if_addr = 32'h0000_0040;
    bus.if_req  = 1'b1;
    run(40);
    ack_en = 1'b1;
    push(1'b1, 32'h0000_0044, 1'b1, 32'h7777_8888, 4'hF, 1'b0, 1'b0);
    bus.dm_addr = 32'h0000_0044; bus.dm_we = 1'b1;
    bus.dm_wdata = 32'h7777_8888; bus.dm_be = 4'hF;
    bus.dm_req = 1'b1;
    run(20);
    chk("bus_err_sticky", bus_err, 32'd1);

    // reset during a data transaction with the streak at its limit
    hold_f = 1'b1; hold_d = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b1, 32'h0000_0500, 1'b1, 32'hFACE_0001, 4'hF, 1'b0, (i != 0));
    bus.if_addr = 32'h0000_0080;
    bus.dm_addr = 32'h0000_0500; bus.dm_we = 1'b1;
    bus.dm_wdata = 32'hFACE_0001; bus.dm_be = 4'hF;
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    done0 = n_done;
    b = 60;
    while ((n_done - done0) < 3 && b > 0) begin tick(); b--; end
    ack_en = 1'b0;
    while (!in_flight && b > 0) begin tick(); b--; end
    chk("t7_fourth_issued", in_flight, 32'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_mem_req", bus.mem_req, 32'd0);
    chk("t7_rst_mem_we", bus.mem_we, 32'd0);
    chk("t7_rst_stall_m", stall_m, 32'd0);
    chk("t7_rst_stall_f", stall_f, 32'd0);
    chk("t7_rst_if_valid", bus.if_valid, 32'd0);
    chk("t7_rst_dm_valid", bus.dm_valid, 32'd0);
    chk("t7_rst_bus_err", bus_err, 32'd0);
    exp_q.delete();
    in_flight = 1'b0; req_cycles = 0; exp_err = 1'b0;
    ack_en = 1'b1; bus.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b1, 32'h0000_0500, 1'b1, 32'hFACE_0001, 4'hF, 1'b0, (i != 0));
    push(1'b0, 32'h0000_0080, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t7_post_bus_err", bus_err, 32'd0);
    run(100);
    hold_f = 1'b0; hold_d = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
